mem_access_seq: RTL
===================

// Module: mem_access_seq
// PURPOSE
//  Load/store sequencer directly upstream of MEMORY (vector data memory, 4 x 8-bit lanes per 32-bit word).
//  Accepts one request at a time from the pipeline over a valid/ready handshake.
//  Drives MEMORY's A/WDV/WDS/POS/WE/E/S pins and sequences multi-beat accesses (unpack, burst load).
//  Returns load data over a valid/ready response channel.
// PARAMETERS
//  AW      17  memory word-address width (matches MEMORY.A)
//  DW      32  data width (4 lanes x 8 bit)
//  LW      8   burst length field width; max burst = 2**LW-1 words
//  MEM_LAT 1   MEMORY read latency in clocks (address sampled at edge k, RD valid after edge k+MEM_LAT)
// PORTS
//  CLK        in   1    clock, rising edge
//  RST        in   1    synchronous reset, active high
//  REQ_VALID  in   1    request present
//  REQ_READY  out  1    sequencer idle and able to accept
//  REQ_OP     in   3    0 LDV, 1 STV, 2 STE, 3 LDE, 4 UNPK, 5 LDB; 6-7 illegal
//  REQ_ADDR   in   AW   start word address
//  REQ_WDV    in   DW   vector store data (STV)
//  REQ_WDS    in   DW   scalar store data; bits [7:0] used (STE)
//  REQ_POS    in   2    lane index (STE, LDE)
//  REQ_LEN    in   LW   burst word count (LDB); 0 treated as 1
//  RESP_VALID out  1    load data beat present
//  RESP_READY in   1    consumer accepts beat
//  RESP_DATA  out  DW   load data
//  RESP_LAST  out  1    final beat of the request
//  ERR        out  1    one-cycle pulse: illegal opcode accepted
//  BUSY       out  1    state != IDLE
//  MEM_A      out  AW   to MEMORY.A
//  MEM_WDV    out  DW   to MEMORY.WDV
//  MEM_WDS    out  DW   to MEMORY.WDS
//  MEM_POS    out  2    to MEMORY.POS
//  MEM_WE     out  1    to MEMORY.WE
//  MEM_E      out  1    to MEMORY.E
//  MEM_S      out  1    to MEMORY.S
//  MEM_RD     in   DW   from MEMORY.RD
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> (store: IDLE) | (load: WAIT -> RESP -> ISSUE for next beat, or IDLE).
//  Reset: state IDLE; REQ_READY=1; RESP_VALID, RESP_LAST, ERR, BUSY, MEM_WE/E/S = 0; MEM_A, MEM_WDV, MEM_WDS, MEM_POS, RESP_DATA = 0.
//  IDLE: REQ_READY=1. REQ_VALID&REQ_READY at edge N latches op/addr/data/pos/len. Next state is ISSUE, or IDLE with ERR=1 for one cycle (illegal op; no memory access).
//  ISSUE (exactly 1 cycle): MEM_* driven from latched registers only (no comb path from REQ_* to MEM_*).
//    LDV: WE=0, E=0, S=0.   STV: WE=1, E=0, MEM_WDV=data.   STE: WE=1, E=1, MEM_WDS=data, MEM_POS=pos.
//    LDE: E=1, S=1, POS=pos.   UNPK: S=1, E=0, POS=beat (0 then 1, same addr).   LDB: plain read of addr+beat.
//  Outside ISSUE: MEM_WE/E/S=0; MEM_A/WDV/WDS/POS hold last values.
//  Stores: write happens at edge N+1; REQ_READY=1 again after edge N+1; no response beat.
//  WAIT: MEM_LAT cycles. MEM_RD captured into RESP_DATA at the last WAIT edge.
//    MEM_LAT=1: RESP_VALID rises after edge N+2.
//  RESP: RESP_VALID=1; RESP_DATA/RESP_LAST stable until RESP_READY. On handshake, go ISSUE for the next beat, else IDLE.
//    No bubble between handshake and next ISSUE.
//  Beats: LDV/LDE 1; UNPK 2; LDB max(REQ_LEN,1). RESP_LAST=1 only on the final beat.
//  LDB address: (start+beat) mod 2**AW; 2**AW-1 wraps to 0.
//  Beat counter is LW bits.
//  REQ_VALID while busy is ignored; the requester must hold it (REQ_READY=0).
//  RST in any state aborts next edge: no further MEM_WE, pending response dropped, all outputs at reset values.
// TESTING
//  1 STV addr 5..9 data i*10, then LDV addr 5..9 -> RESP_DATA 50,60,70,80,90, RESP_LAST=1 each; MEM_WE high exactly 1 cycle per store.
//  2 STV addr1 0x03020100; STE addr1 pos3 WDS 0xA; LDV addr1 -> 0x0A020100.
//  3 UNPK addr1 -> beats 0x01010000, then 0x0A0A0202 with RESP_LAST. LDE addr1 pos0..3 -> 0x0, 0x1, 0x2, 0xA.
//  4 LDB addr5 len5 with RESP_READY low 3 cycles on beat 2 -> data held stable; 5 beats 50..90; LAST only on 90; REQ_READY=0 until done.
//  5 LDB addr 0x1FFFF len2 -> MEM_A 0x1FFFF then 0x00000. LEN=0 -> single beat. OP=6 -> ERR 1-cycle pulse, no MEM_WE/E/S, back to IDLE.
//  6 RST asserted during beat 3 of LDB len5 -> next cycle BUSY=0, RESP_VALID=0, REQ_READY=1; a new LDV completes normally.

Source files
------------

// File: rtl/mem_access_seq.sv
// Load/store sequencer in front of the vector data memory: accepts one request at a time,
// drives the memory pins for each beat and returns load beats over a valid/ready channel.
module mem_access_seq #(
  parameter int AW      = 17,
  parameter int DW      = 32,
  parameter int LW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [2:0]    REQ_OP,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [DW-1:0] REQ_WDV,
  input  logic [DW-1:0] REQ_WDS,
  input  logic [1:0]    REQ_POS,
  input  logic [LW-1:0] REQ_LEN,
  output logic          RESP_VALID,
  input  logic          RESP_READY,
  output logic [DW-1:0] RESP_DATA,
  output logic          RESP_LAST,
  output logic          ERR,
  output logic          BUSY,
  output logic [AW-1:0] MEM_A,
  output logic [DW-1:0] MEM_WDV,
  output logic [DW-1:0] MEM_WDS,
  output logic [1:0]    MEM_POS,
  output logic          MEM_WE,
  output logic          MEM_E,
  output logic          MEM_S,
  input  logic [DW-1:0] MEM_RD
);

  localparam logic [2:0] OP_LDV  = 3'd0;
  localparam logic [2:0] OP_STV  = 3'd1;
  localparam logic [2:0] OP_STE  = 3'd2;
  localparam logic [2:0] OP_LDE  = 3'd3;
  localparam logic [2:0] OP_UNPK = 3'd4;
  localparam logic [2:0] OP_LDB  = 3'd5;

  localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      op_reg, op_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   wdv_reg, wdv_next;
  logic [DW-1:0]   wds_reg, wds_next;
  logic [1:0]      pos_reg, pos_next;
  logic [LW-1:0]   beat_reg, beat_next;
  logic [LW-1:0]   last_reg, last_next;
  logic [WCW-1:0]  wait_reg, wait_next;
  logic [DW-1:0]   resp_data_reg, resp_data_next;
  logic            err_reg, err_next;
  logic [AW-1:0]   mem_a_reg, mem_a_next;
  logic [DW-1:0]   mem_wdv_reg, mem_wdv_next;
  logic [DW-1:0]   mem_wds_reg, mem_wds_next;
  logic [1:0]      mem_pos_reg, mem_pos_next;
  logic            mem_we_reg, mem_we_next;
  logic            mem_e_reg, mem_e_next;
  logic            mem_s_reg, mem_s_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      addr_reg      <= '0;
      wdv_reg       <= '0;
      wds_reg       <= '0;
      pos_reg       <= '0;
      beat_reg      <= '0;
      last_reg      <= '0;
      wait_reg      <= '0;
      resp_data_reg <= '0;
      err_reg       <= 1'b0;
      mem_a_reg     <= '0;
      mem_wdv_reg   <= '0;
      mem_wds_reg   <= '0;
      mem_pos_reg   <= '0;
      mem_we_reg    <= 1'b0;
      mem_e_reg     <= 1'b0;
      mem_s_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      addr_reg      <= addr_next;
      wdv_reg       <= wdv_next;
      wds_reg       <= wds_next;
      pos_reg       <= pos_next;
      beat_reg      <= beat_next;
      last_reg      <= last_next;
      wait_reg      <= wait_next;
      resp_data_reg <= resp_data_next;
      err_reg       <= err_next;
      mem_a_reg     <= mem_a_next;
      mem_wdv_reg   <= mem_wdv_next;
      mem_wds_reg   <= mem_wds_next;
      mem_pos_reg   <= mem_pos_next;
      mem_we_reg    <= mem_we_next;
      mem_e_reg     <= mem_e_next;
      mem_s_reg     <= mem_s_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    wdv_next       = wdv_reg;
    wds_next       = wds_reg;
    pos_next       = pos_reg;
    beat_next      = beat_reg;
    last_next      = last_reg;
    wait_next      = wait_reg;
    resp_data_next = resp_data_reg;
    err_next       = 1'b0;
    mem_a_next     = mem_a_reg;
    mem_wdv_next   = mem_wdv_reg;
    mem_wds_next   = mem_wds_reg;
    mem_pos_next   = mem_pos_reg;
    mem_we_next    = 1'b0;
    mem_e_next     = 1'b0;
    mem_s_next     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (REQ_VALID) begin
          op_next   = REQ_OP;
          addr_next = REQ_ADDR;
          wdv_next  = REQ_WDV;
          wds_next  = REQ_WDS;
          pos_next  = REQ_POS;
          beat_next = '0;
          // last_reg holds the index of the final beat, not the beat count
          case (REQ_OP)
            OP_UNPK: last_next = LW'(1);
            OP_LDB:  last_next = (REQ_LEN == '0) ? '0 : REQ_LEN - LW'(1);
            default: last_next = '0;
          endcase
          if (REQ_OP <= OP_LDB) begin
            state_next = S_ISSUE;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (op_reg == OP_STV || op_reg == OP_STE) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_WAIT;
          wait_next  = WCW'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (wait_reg == '0) begin
          resp_data_next = MEM_RD;
          state_next     = S_RESP;
        end else begin
          wait_next = wait_reg - WCW'(1);
        end
      end
      S_RESP: begin
        if (RESP_READY) begin
          if (beat_reg == last_reg) begin
            state_next = S_IDLE;
          end else begin
            beat_next  = beat_reg + LW'(1);
            state_next = S_ISSUE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Memory pins are registered on entry to ISSUE so they are valid for exactly that cycle.
    if (state_next == S_ISSUE) begin
      mem_a_next = (op_next == OP_LDB) ? addr_next + AW'(beat_next) : addr_next;
      case (op_next)
        OP_STV: begin
          mem_we_next  = 1'b1;
          mem_wdv_next = wdv_next;
        end
        OP_STE: begin
          mem_we_next  = 1'b1;
          mem_e_next   = 1'b1;
          mem_wds_next = wds_next;
          mem_pos_next = pos_next;
        end
        OP_LDE: begin
          mem_e_next   = 1'b1;
          mem_s_next   = 1'b1;
          mem_pos_next = pos_next;
        end
        OP_UNPK: begin
          mem_s_next   = 1'b1;
          mem_pos_next = beat_next[1:0];
        end
        default: ;
      endcase
    end
  end

  assign REQ_READY  = (state_reg == S_IDLE);
  assign BUSY       = (state_reg != S_IDLE);
  assign RESP_VALID = (state_reg == S_RESP);
  assign RESP_LAST  = (state_reg == S_RESP) && (beat_reg == last_reg);
  assign RESP_DATA  = resp_data_reg;
  assign ERR        = err_reg;
  assign MEM_A      = mem_a_reg;
  assign MEM_WDV    = mem_wdv_reg;
  assign MEM_WDS    = mem_wds_reg;
  assign MEM_POS    = mem_pos_reg;
  assign MEM_WE     = mem_we_reg;
  assign MEM_E      = mem_e_reg;
  assign MEM_S      = mem_s_reg;

endmodule
